// File: rtl/hazard_unit_if.sv
// Hazard unit connection bundle: the ID-stage instruction description and EX branch
// signal going in, and the forwarding selects, stall/flush controls and counters coming out.
interface hazard_unit_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic        b_taken;

    logic [1:0]  forward_rrd1;
    logic [1:0]  forward_rrd2;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, b_taken,
        input  forward_rrd1, forward_rrd2, stall_if, stall_id, flush_id, flush_ex,
        input  stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, b_taken,
        output forward_rrd1, forward_rrd2, stall_if, stall_id, flush_id, flush_ex,
        output stall_count, flush_count
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: shadows the EX/MEM/WB destination registers to produce operand
// forwarding selects, load-use stalls, branch flushes and saturating event counters.
module hazard_unit (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);

    typedef enum logic [1:0] {
        FWD_NO = 2'b00,
        FWD_DM = 2'b01,
        FWD_WB = 2'b10
    } fwd_e;

    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_regwrite;
    logic        ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic        load_use;
    logic        stall;
    logic        branch;
    logic        bubble_ex;
    fwd_e        fwd1;
    fwd_e        fwd2;

    function automatic fwd_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        fwd_e sel;
        sel = FWD_NO;
        if (m_we && (m_rd != '0) && (m_rd == rs)) begin
            sel = FWD_DM;
        end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Outputs are gated by reset so they drop immediately, independent of the inputs.
    always_comb begin
        load_use = 1'b0;
        if (!reset && hz.id_valid && ex_is_load && ex_regwrite && (ex_rd != '0)) begin
            load_use = (ex_rd == hz.id_rs1) || (ex_rd == hz.id_rs2);
        end
        branch    = hz.b_taken && !reset;
        stall     = load_use && !branch;
        bubble_ex = load_use || branch;
        fwd1      = fwd_select(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd2      = fwd_select(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

    assign hz.forward_rrd1 = fwd1;
    assign hz.forward_rrd2 = fwd2;
    assign hz.stall_if     = stall;
    assign hz.stall_id     = stall;
    assign hz.flush_id     = branch;
    assign hz.flush_ex     = bubble_ex;
    assign hz.stall_count  = stall_cnt;
    assign hz.flush_count  = flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_regwrite  <= 1'b0;
            ex_is_load   <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            if (bubble_ex) begin
                ex_rd       <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_regwrite <= 1'b0;
                ex_is_load  <= 1'b0;
            end else begin
                ex_rd       <= hz.id_rd;
                ex_rs1      <= hz.id_rs1;
                ex_rs2      <= hz.id_rs2;
                ex_regwrite <= hz.id_regwrite && hz.id_valid;
                ex_is_load  <= hz.id_is_load && hz.id_valid;
            end
            // The instruction leaving EX keeps its own regwrite, so a taken jal still links.
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a vector table walked one cycle per entry, then
// hand-written sequences for reset during a stall and counter saturation.
module tb_hazard_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hazard_unit_if hz ();

    hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        bt;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        st;
        logic        fid;
        logic        fex;
        logic [31:0] sc;
        logic [31:0] fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input int v, input int rs1, input int rs2, input int rd,
        input int rw, input int ld, input int bt,
        input int f1, input int f2, input int st, input int fid, input int fex,
        input int sc, input int fc
    );
        vec_t r;
        r.v   = 1'(v);
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.rd  = 5'(rd);
        r.rw  = 1'(rw);
        r.ld  = 1'(ld);
        r.bt  = 1'(bt);
        r.f1  = 2'(f1);
        r.f2  = 2'(f2);
        r.st  = 1'(st);
        r.fid = 1'(fid);
        r.fex = 1'(fex);
        r.sc  = 32'(sc);
        r.fc  = 32'(fc);
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_id(input int v, input int rs1, input int rs2, input int rd,
                            input int rw, input int ld, input int bt);
        hz.id_valid    = 1'(v);
        hz.id_rs1      = 5'(rs1);
        hz.id_rs2      = 5'(rs2);
        hz.id_rd       = 5'(rd);
        hz.id_regwrite = 1'(rw);
        hz.id_is_load  = 1'(ld);
        hz.b_taken     = 1'(bt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic [1:0] f1, input logic [1:0] f2,
                           input logic st, input logic fid, input logic fex,
                           input logic [31:0] sc, input logic [31:0] fc);
        chk("fwd1",     idx, 32'(hz.forward_rrd1), 32'(f1));
        chk("fwd2",     idx, 32'(hz.forward_rrd2), 32'(f2));
        chk("stall_if", idx, 32'(hz.stall_if),     32'(st));
        chk("stall_id", idx, 32'(hz.stall_id),     32'(st));
        chk("flush_id", idx, 32'(hz.flush_id),     32'(fid));
        chk("flush_ex", idx, 32'(hz.flush_ex),     32'(fex));
        chk("stall_ct", idx, hz.stall_count,       sc);
        chk("flush_ct", idx, hz.flush_count,       fc);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //               v rs1 rs2 rd rw ld bt  f1 f2 st fid fex sc fc
        vecs.push_back(mk(1,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // add x3,x1,x2
        vecs.push_back(mk(1,  3,  5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // sub x4,x3,x5
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // sub in EX: DM
        vecs.push_back(mk(1,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // add x3
        vecs.push_back(mk(1,  9, 10, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // independent
        vecs.push_back(mk(1, 12,  3,11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // use x3 as rs2
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0)); // WB hit
        vecs.push_back(mk(1,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // add x3
        vecs.push_back(mk(1, 14, 15,13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // independent
        vecs.push_back(mk(1, 17, 18,16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // independent
        vecs.push_back(mk(1, 20,  3,19, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // use x3 as rs2
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // too far: NO
        vecs.push_back(mk(1,  1,  0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // lw x5
        vecs.push_back(mk(1,  5,  7, 6, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0)); // add x6,x5,x7: stall
        vecs.push_back(mk(1,  5,  7, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // held, no stall
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0)); // load value from WB
        vecs.push_back(mk(1,  1,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // write x0
        vecs.push_back(mk(1,  0,  0,20, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // add x20,x0,x0
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // x0 in MEM: NO
        vecs.push_back(mk(1,  1,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // lw x0
        vecs.push_back(mk(1,  0,  2,21, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // use x0: no stall
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1,  1,  0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // lw x7
        vecs.push_back(mk(1,  7,  7, 8, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0)); // load-use + branch
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // bubble in EX
        vecs.push_back(mk(1,  0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // jal x1
        vecs.push_back(mk(1, 10, 11, 9, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1)); // taken, wrong path
        vecs.push_back(mk(1,  1, 13,12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2)); // target uses x1
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 2)); // link value via WB
        vecs.push_back(mk(1,  1,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2)); // add x3 (older)
        vecs.push_back(mk(1,  4,  5, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2)); // add x3 (newer)
        vecs.push_back(mk(1,  3,  3, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2)); // sub x6,x3,x3
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2)); // DM beats WB
        vecs.push_back(mk(0,  0,  0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2)); // invalid "load x3"
        vecs.push_back(mk(1,  3,  0,10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2)); // no stall
        vecs.push_back(mk(0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2)); // no forward

        // Reset held with live inputs, including a taken branch.
        reset = 1'b1;
        drive_id(1, 3, 3, 5, 1, 1, 1);
        step();
        step();
        @(negedge clk);
        chk_all(-1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive_id(int'(vecs[i].v), int'(vecs[i].rs1), int'(vecs[i].rs2),
                     int'(vecs[i].rd), int'(vecs[i].rw), int'(vecs[i].ld), int'(vecs[i].bt));
            @(negedge clk);
            chk_all(i, vecs[i].f1, vecs[i].f2, vecs[i].st, vecs[i].fid, vecs[i].fex,
                    vecs[i].sc, vecs[i].fc);
            step();
        end

        // Reset pulsed in the middle of a load-use stall.
        drive_id(1, 1, 0, 5, 1, 1, 0);
        step();
        drive_id(1, 5, 7, 6, 1, 0, 0);
        @(negedge clk);
        chk("rst_pre_stall", 100, 32'(hz.stall_if), 32'd1);
        reset = 1'b1;
        hz.b_taken = 1'b1;
        #1;
        chk_all(101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        reset = 1'b0;
        hz.b_taken = 1'b0;
        @(negedge clk);
        chk("rst_discard", 102, 32'(hz.stall_if), 32'd0);
        step();

        // Stall counter saturation.
        drive_id(1, 1, 0, 5, 1, 1, 0);
        step();
        drive_id(1, 5, 7, 6, 1, 0, 0);
        @(negedge clk);
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        chk("sat_preset", 103, hz.stall_count, 32'hFFFF_FFFE);
        chk("sat_stall",  104, 32'(hz.stall_id), 32'd1);
        step();
        chk("sat_reach",  105, hz.stall_count, 32'hFFFF_FFFF);
        drive_id(1, 1, 0, 5, 1, 1, 0);
        step();
        drive_id(1, 5, 7, 6, 1, 0, 0);
        @(negedge clk);
        chk("sat_stall2", 106, 32'(hz.stall_if), 32'd1);
        step();
        chk("sat_hold",   107, hz.stall_count, 32'hFFFF_FFFF);

        // Flush counter saturation.
        drive_id(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        force dut.flush_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.flush_cnt;
        step();
        chk("fsat_hold", 108, hz.flush_count, 32'hFFFF_FFFF);
        drive_id(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 id_valid  input  1  ID stage holds a real instruction (0 = bubble).
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 id_rd  input  5  destination register index of the instruction in ID.
REQ-006 id_regwrite  input  1  ID instruction writes id_rd.
REQ-007 id_is_load  input  1  ID instruction is a load; its result is available only at WB.
REQ-008 b_taken  input  1  EX branch/jump taken this cycle.
REQ-009 forward_rrd1, forward_rrd2  output  `FORWARDSRC_BUS (2)  EX operand source select: 2'b00 = `EXE_FORWARDSRC_*_NO, 2'b01 = _DM (m_regwd), 2'b10 = _WB (w_regwd); 2'b11 is never driven.
REQ-010 stall_if, stall_id  output  1 each  hold the PC and the IF/ID register.
REQ-011 flush_id, flush_ex  output  1 each  load a bubble into IF/ID and ID/EX at the next edge.
REQ-012 stall_count, flush_count  output  32 each  saturating performance counters.

Function
REQ-013 Shadow pipeline: registered entries EX{rd, rs1, rs2, regwrite, is_load}, MEM{rd, regwrite}, WB{rd, regwrite} mirror the datapath stage registers.
REQ-014 Each edge without stall or flush: EX <- ID inputs (regwrite and is_load gated by id_valid), MEM <- EX, WB <- MEM.
REQ-015 Load-use stall = id_valid & EX.is_load & EX.regwrite & EX.rd != 0 & (EX.rd == id_rs1 | EX.rd == id_rs2), computed combinationally.
REQ-016 On a load-use stall: stall_if = stall_id = 1, flush_ex = 1; the EX entry becomes a bubble (regwrite = 0, is_load = 0); MEM and WB still advance.
REQ-017 On b_taken: flush_id = flush_ex = 1 and the EX entry becomes a bubble; the branching instruction still advances EX -> MEM with its own regwrite (jal/jalr link write preserved).
REQ-018 When b_taken and a load-use stall coincide, b_taken wins: stall_if = stall_id = 0 and the stall is not counted.
REQ-019 forward_rrdN = DM when MEM.regwrite & MEM.rd != 0 & MEM.rd == EX.rsN; otherwise WB when WB.regwrite & WB.rd != 0 & WB.rd == EX.rsN; otherwise NO. DM has priority over WB. Computed combinationally from registered state, with 0-cycle latency to EX.
REQ-020 Register x0 is never a forwarding or stall source.
REQ-021 A load in MEM is never a DM forwarding source for its loaded value, because REQ-015 guarantees at least one bubble between a load and a dependent instruction. The WB match supplies the loaded value.
REQ-022 stall_count increments by 1 on each cycle with a counted load-use stall; flush_count increments by 1 on each b_taken cycle; both hold at 32'hFFFF_FFFF.
REQ-023 Register-file write-then-read between WB and ID is outside the scope of this block.

Reset
REQ-024 While reset is high, asynchronously: all shadow entries are invalid (regwrite = 0, is_load = 0, indices = 0), forward_rrd1 = forward_rrd2 = NO, all stall and flush outputs = 0, and both counters = 0.
REQ-025 Reset asserted mid-stall or mid-flush discards the pending event. The first edge after release samples ID normally.

Verification
REQ-026 ID = add x3,x1,x2; next ID = sub x4,x3,x5 -> with sub in EX: forward_rrd1 = 01 (DM), forward_rrd2 = 00.
REQ-027 add x3 followed by two independent instructions, then use x3 as rs2 -> forward_rrd2 = 00 when the use is in EX (no hit). With one independent instruction in between: forward_rrd2 = 10 (WB).
REQ-028 lw x5 in EX, ID = add x6,x5,x7 -> stall_if = stall_id = flush_ex = 1 for exactly 1 cycle and stall_count = 1. Next cycle, with add in EX: forward_rrd1 = 10.
REQ-029 Write x0 in MEM, EX.rs1 = 0 -> forward_rrd1 = 00. lw x0 followed by a use of x0 -> no stall.
REQ-030 b_taken = 1 in the same cycle as a load-use match -> flush_id = flush_ex = 1, stall_if = 0, flush_count = 1, stall_count = 0. The next cycle's EX entry is a bubble and produces no forwarding.
REQ-031 Reset pulsed during a stall cycle -> all outputs return to 0/NO immediately. Counters preset near saturation (4 billion+ stalls forced) -> stall_count holds at FFFF_FFFF.
